// File: rtl/vx_mem_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// VX_gpu_pkg: shared memory-bus request/response types and sizing.  Rev 1.0
// ---------------------------------------------------------------------------
package VX_gpu_pkg;

  localparam int MEM_DATA_SIZE  = 64;
  localparam int MEM_ADDR_WIDTH = 26;
  localparam int MEM_TAG_WIDTH  = 8;
  localparam int MEM_DEPTH_DFLT = 1024;
  localparam int MEM_IDX_W      = $clog2(MEM_DEPTH_DFLT);

  typedef struct packed {
    logic                       rw;
    logic [MEM_ADDR_WIDTH-1:0]  addr;
    logic [MEM_DATA_SIZE-1:0]   byteen;
    logic [MEM_DATA_SIZE*8-1:0] data;
    logic [MEM_TAG_WIDTH-1:0]   tag;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_SIZE*8-1:0] data;
    logic [MEM_TAG_WIDTH-1:0]   tag;
  } mem_rsp_t;

endpackage

`default_nettype wire

// File: rtl/vx_mem_responder_rsp_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vx_mem_rsp_queue: synchronous response FIFO, head driven from storage flops.
// Rev 1.0
// ---------------------------------------------------------------------------
module vx_mem_rsp_queue
  import VX_gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push_i,
  input  mem_rsp_t push_data_i,
  output logic     full_o,
  output logic     valid_o,
  output mem_rsp_t data_o,
  input  logic     ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  mem_rsp_t               slots_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;
  logic                   pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);
  assign data_o  = slots_q[rd_ptr_q];
  assign pop     = valid_o & ready_i;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_i && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_i) begin
      slots_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
    !(pop && (count_q == '0)));

  a_head_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));

endmodule

`default_nettype wire

// File: rtl/vx_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vx_mem_responder: SRAM-backed bus responder, tagged fixed-latency reads
// with credit flow control.  Rev 1.0
// ---------------------------------------------------------------------------
module vx_mem_responder
  import VX_gpu_pkg::*;
#(
  parameter int DATA_SIZE      = MEM_DATA_SIZE,
  parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int TAG_WIDTH      = MEM_TAG_WIDTH,
  parameter int MEM_DEPTH      = MEM_DEPTH_DFLT,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mem_req_valid,
  input  logic                   mem_req_rw,
  input  logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic [DATA_SIZE-1:0]   mem_req_byteen,
  input  logic [DATA_SIZE*8-1:0] mem_req_data,
  input  logic [TAG_WIDTH-1:0]   mem_req_tag,
  output logic                   mem_req_ready,
  output logic                   mem_rsp_valid,
  output logic [DATA_SIZE*8-1:0] mem_rsp_data,
  output logic [TAG_WIDTH-1:0]   mem_rsp_tag,
  input  logic                   mem_rsp_ready,
  output logic                   busy
);

  // Struct field widths come from the package, so the width parameters
  // above must stay equal to the package constants.
  localparam int DATA_W = DATA_SIZE * 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STAGES = LATENCY - 1;
  localparam int CRD_W  = $clog2(RSP_QUEUE_SIZE + 1);
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(RSP_QUEUE_SIZE);

  mem_req_t          req;
  logic [IDX_W-1:0]  req_idx;
  logic              req_fire;
  logic              wr_fire;
  logic              rd_fire;
  logic              rsp_fire;
  logic              addr_hi_unused;

  logic [CRD_W-1:0]  credits_q;
  logic [CRD_W-1:0]  credits_d;
  logic              ready_en_q;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [STAGES-1:0] pipe_vld_q;
  mem_rsp_t          pipe_q [STAGES];

  mem_rsp_t          q_data;
  logic              q_full;

  assign req = '{rw:     mem_req_rw,
                 addr:   mem_req_addr,
                 byteen: mem_req_byteen,
                 data:   mem_req_data,
                 tag:    mem_req_tag};

  // Upper line-address bits alias onto the array.
  assign req_idx        = req.addr[IDX_W-1:0];
  assign addr_hi_unused = ^req.addr[ADDR_WIDTH-1:IDX_W];

  assign mem_req_ready = ready_en_q & (credits_q != '0);
  assign req_fire      = mem_req_valid & mem_req_ready;
  assign wr_fire       = req_fire & req.rw;
  assign rd_fire       = req_fire & ~req.rw;
  assign rsp_fire      = mem_rsp_valid & mem_rsp_ready;
  assign busy          = (credits_q != CRD_MAX);

  always_comb begin
    credits_d = credits_q;
    case ({rd_fire, rsp_fire})
      2'b10:   credits_d = credits_q - CRD_W'(1);
      2'b01:   credits_d = credits_q + CRD_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  // ready_en_q holds ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits_q  <= CRD_MAX;
      ready_en_q <= 1'b0;
      pipe_vld_q <= '0;
    end else begin
      credits_q     <= credits_d;
      ready_en_q    <= 1'b1;
      pipe_vld_q[0] <= rd_fire;
      for (int s = 1; s < STAGES; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < DATA_SIZE; b++) begin
        if (req.byteen[b]) begin
          mem_q[req_idx][b*8 +: 8] <= req.data[b*8 +: 8];
        end
      end
    end
  end

  // First stage is the registered array read; the rest are pure delay.
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      pipe_q[0] <= '{data: mem_q[req_idx], tag: req.tag};
    end
    for (int s = 1; s < STAGES; s++) begin
      pipe_q[s] <= pipe_q[s-1];
    end
  end

  vx_mem_rsp_queue #(
    .DEPTH       (RSP_QUEUE_SIZE)
  ) u_rsp_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (pipe_vld_q[STAGES-1]),
    .push_data_i (pipe_q[STAGES-1]),
    .full_o      (q_full),
    .valid_o     (mem_rsp_valid),
    .data_o      (q_data),
    .ready_i     (mem_rsp_ready)
  );

  assign mem_rsp_data = q_data.data;
  assign mem_rsp_tag  = q_data.tag;

  a_credit_max: assert property (@(posedge clk) disable iff (!reset_n)
    credits_q <= CRD_MAX);

  a_credit_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(rd_fire && (credits_q == '0)));

  a_credit_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(rsp_fire && !rd_fire && (credits_q == CRD_MAX)));

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(pipe_vld_q[STAGES-1] && q_full && !rsp_fire));

endmodule

`default_nettype wire

// File: tb/tb_vx_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vx_mem_responder: directed stimulus with scoreboard/monitor checking.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vx_mem_responder;

  localparam int DS = 64;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int DW = DS * 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          mem_req_valid = 1'b0;
  logic          mem_req_rw = 1'b0;
  logic [AW-1:0] mem_req_addr = '0;
  logic [DS-1:0] mem_req_byteen = '0;
  logic [DW-1:0] mem_req_data = '0;
  logic [TW-1:0] mem_req_tag = '0;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready = 1'b1;
  logic          busy;

  vx_mem_responder #(
    .DATA_SIZE(DS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .MEM_DEPTH(1024), .LATENCY(4), .RSP_QUEUE_SIZE(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_byteen(mem_req_byteen),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } exp_t;

  exp_t          exp_q[$];
  int            fire_cyc[$];
  logic          fire_busy[$];
  logic [DW-1:0] model [1024];
  int            n_tests = 0;
  int            n_fail = 0;
  int            last_waits = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every response fire, and checks that a
  // stalled response holds its payload.
  logic          hold_vld = 1'b0;
  logic [DW-1:0] hold_d;
  logic [TW-1:0] hold_t;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (reset_n && mem_rsp_valid) begin
      if (hold_vld) begin
        check("rsp data stable", mem_rsp_data, hold_d);
        check("rsp tag stable", DW'(mem_rsp_tag), DW'(hold_t));
      end
      if (mem_rsp_ready) begin
        hold_vld = 1'b0;
        fire_cyc.push_back(cyc);
        fire_busy.push_back(busy);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected rsp: tag %0h with empty scoreboard", mem_rsp_tag);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp data", mem_rsp_data, mon_e.d);
          check("rsp tag", DW'(mem_rsp_tag), DW'(mon_e.t));
        end
      end else begin
        hold_vld = 1'b1;
        hold_d   = mem_rsp_data;
        hold_t   = mem_rsp_tag;
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  // Issue one request; push the expected read response at acceptance.
  task automatic do_req(input logic rw, input logic [AW-1:0] addr, input logic [DS-1:0] be,
                        input logic [DW-1:0] data, input logic [TW-1:0] tag, output int acc);
    int   waits = 0;
    exp_t e;
    logic [9:0] idx;
    idx = addr[9:0];
    acc = -1;
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_byteen = be;
    mem_req_data   = data;
    mem_req_tag    = tag;
    while (acc < 0 && waits < 200) begin
      @(negedge clk);
      if (mem_req_ready) begin
        acc = cyc;
        if (rw) begin
          for (int b = 0; b < DS; b++)
            if (be[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end else begin
          e.d = model[idx];
          e.t = tag;
          exp_q.push_back(e);
        end
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    mem_req_valid = 1'b0;
    last_waits = waits;
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL req accept timeout: addr %0h", addr);
    end
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [DS-1:0] be);
    int acc;
    do_req(1'b1, addr, be, data, '0, acc);
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [TW-1:0] tag, output int acc);
    do_req(1'b0, addr, '0, '0, tag, acc);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    int acc;
    int acc0;
    int r;
    int tot_waits;
    int k;
    logic [7:0] bv;

    // Reset
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("reset ready", DW'(mem_req_ready), 0);
    check("reset rsp_valid", DW'(mem_rsp_valid), 0);
    check("reset busy", DW'(busy), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post-reset ready", DW'(mem_req_ready), 1);
    check("post-reset busy", DW'(busy), 0);
    @(posedge clk); #1;

    // Write then read, latency 4
    wr(26'h10, {64{8'hA5}}, {DS{1'b1}});
    fire_cyc.delete();
    rd(26'h10, 8'h03, acc);
    drain();
    check("T1 fire count", DW'(fire_cyc.size()), 1);
    if (fire_cyc.size() > 0) check("T1 latency", DW'(fire_cyc[0]), DW'(acc + 4));

    // All-zero byte enables: no-op write
    wr(26'h10, {DW{1'b0}}, {DS{1'b0}});
    rd(26'h10, 8'h13, acc);
    drain();

    // Partial byte write, read-after-write next cycle
    wr(26'h11, {64{8'hFF}}, {DS{1'b1}});
    wr(26'h11, {DW{1'b0}}, 64'h1);
    rd(26'h11, 8'h04, acc);
    drain();

    // Fill all credits with rsp_ready low
    for (int i = 0; i < 8; i++) begin
      bv = 8'(i * 17 + 1);
      wr(26'h20 + 26'(i), {64{bv}}, {DS{1'b1}});
    end
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) rd(26'h20 + 26'(i), 8'(i), acc);
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b1;
    mem_req_addr   = 26'h10;
    mem_req_byteen = {DS{1'b1}};
    mem_req_data   = {DW{1'b0}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("credits exhausted ready", DW'(mem_req_ready), 0);
      @(posedge clk); #1;
    end
    mem_req_valid = 1'b0;
    check("credits exhausted busy", DW'(busy), 1);
    fire_cyc.delete();
    mem_rsp_ready = 1'b1;
    @(negedge clk);
    r = cyc;
    check("ready at first fire", DW'(mem_req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ready after first fire", DW'(mem_req_ready), 1);
    drain();
    check("T3 fire count", DW'(fire_cyc.size()), 8);
    for (int i = 0; i < fire_cyc.size(); i++)
      check("T3 fire cycle", DW'(fire_cyc[i]), DW'(r + i));

    // Continuous reads with rsp_ready high
    fire_cyc.delete();
    fire_busy.delete();
    tot_waits = 0;
    acc0 = 0;
    for (int i = 0; i < 12; i++) begin
      rd((i % 2) ? 26'h11 : 26'h10, 8'(8'h40 + i), acc);
      if (i == 0) acc0 = acc;
      tot_waits += last_waits;
    end
    k = 0;
    while (fire_cyc.size() < 12 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("T4 fire count", DW'(fire_cyc.size()), 12);
    check("T4 no request stall", DW'(tot_waits), 0);
    if (fire_cyc.size() == 12) begin
      check("T4 first latency", DW'(fire_cyc[0]), DW'(acc0 + 4));
      for (int i = 1; i < 12; i++)
        check("T4 back-to-back fire", DW'(fire_cyc[i]), DW'(fire_cyc[0] + i));
      check("T4 busy at last fire", DW'(fire_busy[11]), 1);
      @(negedge clk);
      check("T4 cycle after last fire", DW'(cyc), DW'(fire_cyc[11] + 1));
      check("T4 busy after last fire", DW'(busy), 0);
      @(posedge clk); #1;
    end

    // Address aliasing modulo MEM_DEPTH
    wr(26'h400, {8{64'h0123456789ABCDEF}}, {DS{1'b1}});
    rd(26'h000, 8'h05, acc);
    rd(26'h400, 8'h06, acc);
    drain();

    // Reset with reads in flight
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) rd(26'h11, 8'h70 + 8'(i), acc);
    #2 reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid-reset ready", DW'(mem_req_ready), 0);
    check("mid-reset rsp_valid", DW'(mem_rsp_valid), 0);
    check("mid-reset busy", DW'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("after reset ready", DW'(mem_req_ready), 1);
    check("after reset busy", DW'(busy), 0);
    mem_rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("no stale rsp", DW'(mem_rsp_valid), 0);
    check("credits restored", DW'(busy), 0);
    @(posedge clk); #1;
    rd(26'h10, 8'h09, acc);
    drain();

    check("scoreboard empty", DW'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
